// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address and IF/ID pipeline register.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect traps instead of being truncated.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef WORD_ADDRESS
`define WORD_ADDRESS 16
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 1024
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

module fetch_stage #(
    parameter logic [`XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     redirect_valid,
    input  logic [`XLEN-1:0]         redirect_target,
    output logic [`WORD_ADDRESS-1:0] imem_addr,
    input  logic [`XLEN-1:0]         imem_instruction,
    output logic                     if_id_valid,
    output logic [`XLEN-1:0]         if_id_pc,
    output logic [`XLEN-1:0]         if_id_pc_plus4,
    output logic [`XLEN-1:0]         if_id_instruction,
    output logic                     fetch_misaligned
);

    // Control contract: redirect_valid beats flush and stall; flush drops the
    // entry being fetched while stall only decides whether the PC advances;
    // stall alone freezes both the PC and the IF/ID register.
    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [`XLEN-1:0]  pc;
    logic [`XLEN-1:0]  pc_next;
    logic [`XLEN-1:0]  pc_plus4;
    logic              valid_next;
    logic [`XLEN-1:0]  ipc_next;
    logic [`XLEN-1:0]  ipc4_next;
    logic [`XLEN-1:0]  instr_next;
    logic [`XLEN-1:0]  aligned_target;

    assign pc_plus4       = pc + `XLEN'd4;
    assign imem_addr      = pc[`WORD_ADDRESS+1:2];
    assign aligned_target = {redirect_target[`XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;
    logic misaligned_next;
    assign fetch_misaligned = misaligned_q;
`else
    logic unused_target_bits;
    assign unused_target_bits = ^redirect_target[1:0];
    assign fetch_misaligned   = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        valid_next = if_id_valid;
        ipc_next   = if_id_pc;
        ipc4_next  = if_id_pc_plus4;
        instr_next = if_id_instruction;
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned_next = misaligned_q;
`endif
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    // The instruction fetched this cycle is on the wrong path.
                    valid_next = 1'b0;
                    instr_next = `NOP_INSTRUCTION;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (redirect_target[1:0] != 2'b00) begin
                        state_next      = TRAP;
                        misaligned_next = 1'b1;
                    end else begin
                        pc_next = aligned_target;
                    end
`else
                    pc_next = aligned_target;
`endif
                end else if (flush) begin
                    valid_next = 1'b0;
                    instr_next = `NOP_INSTRUCTION;
                    if (!stall) pc_next = pc_plus4;
                end else if (!stall) begin
                    valid_next = 1'b1;
                    ipc_next   = pc;
                    ipc4_next  = pc_plus4;
                    instr_next = imem_instruction;
                    pc_next    = pc_plus4;
                end
            end
            default: begin
                // Trapped: PC frozen, bubbles until reset.
                valid_next = 1'b0;
                instr_next = `NOP_INSTRUCTION;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= RUN;
            pc                <= RESET_PC;
            if_id_valid       <= 1'b0;
            if_id_pc          <= '0;
            if_id_pc_plus4    <= '0;
            if_id_instruction <= `NOP_INSTRUCTION;
        end else begin
            state             <= state_next;
            pc                <= pc_next;
            if_id_valid       <= valid_next;
            if_id_pc          <= ipc_next;
            if_id_pc_plus4    <= ipc4_next;
            if_id_instruction <= instr_next;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) misaligned_q <= 1'b0;
        else       misaligned_q <= misaligned_next;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reference model checked every cycle plus literal pins.
// Honours FETCH_MISALIGN_TRAP_EN the same way as the design.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef WORD_ADDRESS
`define WORD_ADDRESS 16
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 1024
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

module tb_fetch_stage;

    localparam logic [31:0] NOP = `NOP_INSTRUCTION;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     stall;
    logic                     flush;
    logic                     redirect_valid;
    logic [`XLEN-1:0]         redirect_target;
    logic [`WORD_ADDRESS-1:0] imem_addr;
    logic [`XLEN-1:0]         imem_instruction;
    logic                     if_id_valid;
    logic [`XLEN-1:0]         if_id_pc;
    logic [`XLEN-1:0]         if_id_pc_plus4;
    logic [`XLEN-1:0]         if_id_instruction;
    logic                     fetch_misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:`MEM_SIZE-1];

    // Reference model state.
    logic        chk_en = 1'b0;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [31:0] m_instr;
    logic        m_trap;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .imem_addr         (imem_addr),
        .imem_instruction  (imem_instruction),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instruction (if_id_instruction),
        .fetch_misaligned  (fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] word_idx);
        if (word_idx < `MEM_SIZE) return mem[word_idx];
        return NOP;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
        logic [31:0] w;
        w = (byte_addr >> 2) & ((32'd1 << `WORD_ADDRESS) - 32'd1);
        return w;
    endfunction

    assign imem_instruction = mem_word(32'(imem_addr));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: the rules of the fetch stage applied to the model's own PC each edge.
    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0;
            m_instr = NOP; m_trap = 1'b0; chk_en = 1'b1;
        end else if (m_trap) begin
            m_valid = 1'b0; m_instr = NOP;
        end else if (redirect_valid) begin
            m_valid = 1'b0; m_instr = NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_target % 4 != 0) m_trap = 1'b1;
            else m_pc = redirect_target;
`else
            m_pc = redirect_target - (redirect_target % 4);
`endif
        end else if (flush) begin
            m_valid = 1'b0; m_instr = NOP;
            if (!stall) m_pc = m_pc + 4;
        end else if (!stall) begin
            m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 4;
            m_instr = mem_word(word_of(m_pc));
            m_pc = m_pc + 4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_addr", 32'(imem_addr), word_of(m_pc));
            check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
            check("if_id_pc", if_id_pc, m_ipc);
            check("if_id_pc_plus4", if_id_pc_plus4, m_ipc4);
            check("if_id_instruction", if_id_instruction, m_instr);
            check("fetch_misaligned", 32'(fetch_misaligned), 32'(m_trap));
        end
    end

    task automatic cycle(input logic s, input logic f, input logic rv, input logic [31:0] t);
        stall = s; flush = f; redirect_valid = rv; redirect_target = t;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0080);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < `MEM_SIZE; i++) mem[i] = 32'hC0DE_0000 | i;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;

        do_reset();
        check("reset_valid", 32'(if_id_valid), 32'h0);
        check("reset_instr", if_id_instruction, NOP);
        check("reset_pc", if_id_pc, 32'h0);
        check("reset_pc4", if_id_pc_plus4, 32'h0);
        check("reset_addr", 32'(imem_addr), 32'h0);
        check("reset_trap", 32'(fetch_misaligned), 32'h0);

        // Sequential run: (0,A) (4,B).
        run(1);
        check("seq0_pc", if_id_pc, 32'h0);
        check("seq0_instr", if_id_instruction, 32'hC0DE_0000);
        check("seq0_valid", 32'(if_id_valid), 32'h1);
        run(1);
        check("seq1_pc4", if_id_pc_plus4, 32'h8);
        check("seq1_instr", if_id_instruction, 32'hC0DE_0001);

        // Stall three cycles holding (4,B).
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            check("stall_pc", if_id_pc, 32'h4);
            check("stall_addr", 32'(imem_addr), 32'h2);
        end
        run(1);
        check("after_stall_instr", if_id_instruction, 32'hC0DE_0002);

        // Redirect to 0x40 while holding (8,C).
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        check("redir_bubble_valid", 32'(if_id_valid), 32'h0);
        check("redir_bubble_instr", if_id_instruction, NOP);
        run(1);
        check("redir_pc", if_id_pc, 32'h40);
        check("redir_instr", if_id_instruction, 32'hC0DE_0010);
        run(1);

        // Redirect wins over simultaneous stall and flush.
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0020);
        check("redir_sf_valid", 32'(if_id_valid), 32'h0);
        run(1);
        check("redir_sf_pc", if_id_pc, 32'h20);
        check("redir_sf_instr", if_id_instruction, 32'hC0DE_0008);

        // Flush alone while fetching 0x10 drops that instruction.
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0010);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("flush_valid", 32'(if_id_valid), 32'h0);
        run(1);
        check("flush_pc", if_id_pc, 32'h14);
        check("flush_instr", if_id_instruction, 32'hC0DE_0005);

        // Flush with stall keeps the PC.
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("flush_stall_addr", 32'(imem_addr), 32'h6);
        run(1);
        check("flush_stall_pc", if_id_pc, 32'h18);

        // Out-of-range fetch and PC wrap.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(1);
        check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_id_pc_plus4, 32'h0);
        check("wrap_instr", if_id_instruction, NOP);
        run(1);
        check("wrap_next", if_id_instruction, 32'hC0DE_0000);
        run(2);

        // Reset mid-operation discards the pending redirect.
        do_reset();
        check("midreset_addr", 32'(imem_addr), 32'h0);
        run(3);

        // Misaligned redirect.
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0042);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_flag", 32'(fetch_misaligned), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, (i == 1), 32'h0000_0100);
            check("trap_valid", 32'(if_id_valid), 32'h0);
            check("trap_addr", 32'(imem_addr), 32'h3);
        end
        do_reset();
        check("trap_cleared", 32'(fetch_misaligned), 32'h0);
        run(1);
        check("trap_restart", if_id_instruction, 32'hC0DE_0000);
`else
        check("misalign_addr", 32'(imem_addr), 32'h10);
        run(1);
        check("misalign_pc", if_id_pc, 32'h40);
        check("misalign_flag", 32'(fetch_misaligned), 32'h0);
`endif
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. The memory read is combinational, so the instruction for the current PC arrives in the same cycle. The stage accepts stall, flush and branch/jump redirect from downstream hazard and execute logic. Its IF/ID outputs feed the decode stage.

## Interface
- RESET_PC, default 32'h0000_0000: byte address loaded into the PC on reset; must be 4-byte aligned.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  replace the next IF/ID entry with a bubble.
- redirect_valid  in  1  branch/jump taken; load redirect_target into the PC.
- redirect_target  in  `XLEN  byte address of the new fetch target.
- imem_addr  out  `WORD_ADDRESS  word address to the instruction memory; equals pc[`WORD_ADDRESS+1:2].
- imem_instruction  in  `XLEN  instruction returned by the memory for imem_addr in the same cycle.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  `XLEN  byte PC of the IF/ID instruction.
- if_id_pc_plus4  out  `XLEN  if_id_pc + 4.
- if_id_instruction  out  `XLEN  captured instruction; `NOP_INSTRUCTION when bubbled.
- fetch_misaligned  out  1  sticky misaligned-redirect trap flag (see Configuration).

## Operation
- Internal PC register (`XLEN bits, byte address). imem_addr is a pure combinational slice of the PC.
- Per-cycle priority is reset > trap > redirect > flush/stall > normal.
- Normal (no stall, flush or redirect):
  - IF/ID loads {valid=1, pc, pc+4, imem_instruction}.
  - PC advances to pc+4.
- stall without redirect: PC and all IF/ID outputs hold their values.
- flush without redirect:
  - IF/ID loads a bubble: valid=0, instruction=`NOP_INSTRUCTION, pc and pc_plus4 hold.
  - PC advances to pc+4 if stall=0, and holds if stall=1.
- redirect_valid: this overrides stall and flush.
  - PC is loaded with the target.
  - IF/ID loads a bubble, because the instruction fetched this cycle is on the wrong path.
- Arithmetic: pc+4 wraps modulo 2^`XLEN with no overflow flag.
- Addresses at or beyond `MEM_SIZE words are fetched normally. The memory returns `NOP_INSTRUCTION for these; the stage does no range checking.
- Two-state FSM:
  - RUN: normal operation.
  - TRAP: exists only with the macro defined. PC is frozen, and IF/ID is forced to a bubble every cycle.
  - RUN -> TRAP on a misaligned redirect (macro defined).
  - TRAP -> RUN only via reset.

## Timing
- Reset values:
  - PC = RESET_PC.
  - if_id_valid = 0, if_id_instruction = `NOP_INSTRUCTION.
  - if_id_pc = 0, if_id_pc_plus4 = 0.
  - fetch_misaligned = 0, FSM = RUN.
- Reset asserted mid-operation discards any pending redirect, flush or stall in that cycle.
- Fetch latency: the instruction at a given PC appears on the IF/ID outputs 1 cycle after that PC drives imem_addr.
- Redirect penalty: redirect in cycle N. The target's instruction is valid in IF/ID in cycle N+2, and IF/ID shows exactly one bubble in cycle N+1.
- First valid instruction after reset release: 1 cycle later, at pc = RESET_PC.
- Outputs change only on the rising edge of clk, except imem_addr, which follows the PC register.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_target[1:0] != 0 sets fetch_misaligned=1 on the next edge and enters TRAP.
  - The PC is not updated with the misaligned target.
  - IF/ID loads a bubble, and bubbles continue until reset.
- FETCH_MISALIGN_TRAP_EN not defined:
  - redirect_target[1:0] is ignored; the PC loads {redirect_target[`XLEN-1:2], 2'b00}.
  - fetch_misaligned is tied to 0 and no TRAP state exists.

## Test plan
- Reset then sequential run, RESET_PC=0, memory words 0..3 = A,B,C,D:
  - After reset release, IF/ID shows (0,A), (4,B), (8,C), (12,D) on consecutive cycles.
  - if_id_pc_plus4 = pc+4 each cycle.
- Stall=1 for 3 cycles while IF/ID holds (4,B):
  - IF/ID stays (4,B) and imem_addr stays 2 throughout.
  - Next cycle shows (8,C).
- Redirect to 0x40 while IF/ID holds (8,C):
  - Next cycle: valid=0, instruction=`NOP_INSTRUCTION.
  - Following cycle: (0x40, mem[16]).
- Redirect together with stall=1 and flush=1 in the same cycle: behaviour identical to the previous redirect scenario (the redirect wins).
- Flush alone with stall=0 while fetching 0x10:
  - Next cycle is a bubble.
  - Cycle after that shows (0x14, mem[5]); the 0x10 instruction is dropped.
- Redirect to 0x42:
  - Macro defined: fetch_misaligned=1, bubbles continue indefinitely, imem_addr frozen; reset clears the flag.
  - Macro not defined: the PC loads 0x40.
